// File: rtl/axis_tx_downsizer_pkg.sv
// Shared types and constants for the 32-bit AXI-stream to byte-stream downsizer.
package axis_tx_downsizer_pkg;

    localparam int DATA_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int KEEP_W         = DATA_W / BYTE_W;
    localparam int IDX_W          = $clog2(KEEP_W);
    localparam int LEVEL_W        = 5;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2
    } ser_state_t;

    // One buffered upstream beat; packs to 37 bits.
    typedef struct packed {
        logic              last;
        logic [KEEP_W-1:0] keep;
        logic [DATA_W-1:0] data;
    } beat_t;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [KEEP_W-1:0] k);
        lowest_set = '0;
        for (int i = KEEP_W - 1; i >= 0; i--) begin
            if (k[i]) lowest_set = IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/axis_tx_downsizer_if.sv
// Upstream beat channel and downstream byte channel of the downsizer.
interface axis_tx_downsizer_if;
    import axis_tx_downsizer_pkg::*;

    // Both channels: a transfer happens on the rising edge where valid and
    // ready are both 1; valid and its payload hold steady until then.
    logic              i_tvalid;
    logic              i_tready;
    logic [DATA_W-1:0] i_tdata;
    logic [KEEP_W-1:0] i_tkeep;
    logic              i_tlast;

    logic              o_tvalid;
    logic              o_tready;
    logic [BYTE_W-1:0] o_tdata;
    logic              o_tlast;

    modport slave (
        input  i_tvalid, i_tdata, i_tkeep, i_tlast, o_tready,
        output i_tready, o_tvalid, o_tdata, o_tlast
    );

    modport master (
        output i_tvalid, i_tdata, i_tkeep, i_tlast, o_tready,
        input  i_tready, o_tvalid, o_tdata, o_tlast
    );

endinterface

// File: rtl/axis_word_fifo.sv
// Beat FIFO with a registered head entry; the head is what the serializer loads from.
module axis_word_fifo
    import axis_tx_downsizer_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               wr_valid_i,
    input  beat_t              wr_data_i,
    output logic               wr_ready_o,
    output logic               rd_valid_o,
    output beat_t              rd_data_o,
    input  logic               rd_pop_i,
    output logic [LEVEL_W-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    beat_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] mem_cnt_q, mem_cnt_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    beat_t              head_q, head_d;
    logic               head_vld_q, head_vld_d;
    logic               rdy_q, rdy_d;
    logic               push, pop, mem_rd;

    assign push   = wr_valid_i & rdy_q;
    assign pop    = rd_pop_i & head_vld_q;
    // Head refills from memory only; a beat written this edge is not visible
    // at the head until the next one.
    assign mem_rd = (~head_vld_q | pop) & (mem_cnt_q != '0);

    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q & ~pop;
        if (mem_rd) begin
            head_d     = mem_q[rd_ptr_q];
            head_vld_d = 1'b1;
        end
        wr_ptr_d  = wr_ptr_q + PTR_W'(push);
        rd_ptr_d  = rd_ptr_q + PTR_W'(mem_rd);
        mem_cnt_d = mem_cnt_q + LEVEL_W'(push) - LEVEL_W'(mem_rd);
        level_d   = level_q + LEVEL_W'(push) - LEVEL_W'(pop);
        // Registered ready keeps i_tready low through reset and for one edge after.
        rdy_d     = (level_d < LEVEL_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            level_q    <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            level_q    <= level_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign wr_ready_o = rdy_q;
    assign rd_valid_o = head_vld_q;
    assign rd_data_o  = head_q;
    assign level_o    = level_q;

endmodule

// File: rtl/axis_tx_downsizer.sv
// 32-bit AXI-stream to byte-stream downsizer with keep-based byte skipping.
// Define AXIS_TX_FLUSH_EN to pulse o_flush after a null beat carrying tlast.
module axis_tx_downsizer
    import axis_tx_downsizer_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    axis_tx_downsizer_if.slave  bus,
    output logic                o_flush,
    output logic [LEVEL_W-1:0]  fifo_level,
    output ser_state_t          dbg_state_o
);

    beat_t             in_beat, head;
    logic              head_vld, pop, fifo_rdy;
    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              last_q, last_d;
    logic [IDX_W-1:0]  idx;
    logic [KEEP_W-1:0] keep_after;
    logic              byte_vld, hs, need_load;

    assign in_beat = {bus.i_tlast, bus.i_tkeep, bus.i_tdata};

    axis_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .wr_valid_i (bus.i_tvalid),
        .wr_data_i  (in_beat),
        .wr_ready_o (fifo_rdy),
        .rd_valid_o (head_vld),
        .rd_data_o  (head),
        .rd_pop_i   (pop),
        .level_o    (fifo_level)
    );

    assign bus.i_tready = fifo_rdy;

    // keep_q holds the bytes of the loaded word not yet emitted.
    assign idx        = lowest_set(keep_q);
    assign keep_after = keep_q & ~(KEEP_W'(1) << idx);
    assign byte_vld   = (state_q == ST_SHIFT) && (keep_q != '0);
    assign hs         = byte_vld & bus.o_tready;

    assign bus.o_tvalid = byte_vld;
    assign bus.o_tdata  = byte_vld ? word_q[{idx, 3'b000} +: BYTE_W] : '0;
    assign bus.o_tlast  = byte_vld & last_q & (keep_after == '0);

    always_comb begin
        need_load = 1'b0;
        unique case (state_q)
            ST_IDLE:  need_load = 1'b1;
            ST_SHIFT: need_load = (keep_q == '0) || (hs && keep_after == '0);
            default:  need_load = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        keep_d  = keep_q;
        last_d  = last_q;
        pop     = 1'b0;
        if (hs) keep_d = keep_after;
        // A null beat loads with keep = 0 and is dropped on the following cycle.
        if (need_load) begin
            if (head_vld) begin
                pop     = 1'b1;
                word_d  = head.data;
                keep_d  = head.keep;
                last_d  = head.last;
                state_d = ST_SHIFT;
`ifdef AXIS_TX_FLUSH_EN
                if (head.keep == '0 && head.last) state_d = ST_FLUSH;
`endif
            end else begin
                state_d = ST_IDLE;
                keep_d  = '0;
                last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

`ifdef AXIS_TX_FLUSH_EN
    // FLUSH is entered only after the previous word's final byte handshook.
    assign o_flush = (state_q == ST_FLUSH);
`else
    assign o_flush = 1'b0;
`endif

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axis_tx_downsizer.sv
// Directed bench for axis_tx_downsizer with a byte scoreboard and monitor.
module tb_axis_tx_downsizer;
    import axis_tx_downsizer_pkg::*;

    localparam int HALF = 5;

`ifdef AXIS_TX_FLUSH_EN
    localparam logic FLUSH_ON = 1'b1;
`else
    localparam logic FLUSH_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        o_flush;
    logic [4:0]  fifo_level;
    ser_state_t  dbg_state;

    logic [8:0]  exp_q[$];
    int          flush_exp = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    axis_tx_downsizer_if bus();

    axis_tx_downsizer #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .o_flush     (o_flush),
        .fifo_level  (fifo_level),
        .dbg_state_o (dbg_state)
    );

    always #HALF clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bytes of one beat: ascending index, skipped keep bits, tlast on the top byte.
    task automatic push_exp(input logic [31:0] data, input logic [3:0] keep, input logic last);
        int hi = -1;
        for (int i = 0; i < 4; i++) if (keep[i]) hi = i;
        for (int i = 0; i < 4; i++) begin
            if (keep[i]) exp_q.push_back({last && (i == hi), data[8*i +: 8]});
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
    task automatic push_beat(input logic [31:0] data, input logic [3:0] keep, input logic last);
        int t = 0;
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = data;
        bus.i_tkeep  = keep;
        bus.i_tlast  = last;
        while (!bus.i_tready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("push_ready_timeout", 32'(bus.i_tready), 32'd1);
        if (bus.i_tready) begin
            push_exp(data, keep, last);
            if (FLUSH_ON && keep == 4'b0000 && last) flush_exp++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic in_idle();
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = '0;
        bus.i_tkeep  = '0;
        bus.i_tlast  = 1'b0;
    endtask

    // Counts cycles from the first valid byte until n handshakes; returns with the last one pending.
    task automatic count_burst(input int n, output int cycles, output logic ok);
        int got = 0;
        int t = 0;
        cycles = 0;
        ok = 1'b0;
        while (!bus.o_tvalid && t < 100) begin
            @(negedge clk);
            t++;
        end
        while (t < 400) begin
            cycles++;
            if (bus.o_tvalid && bus.o_tready) got++;
            if (got == n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            t++;
        end
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.o_tvalid) break;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: samples just before each rising edge and scores every byte handshake.
    always begin
        @(negedge clk);
        #(HALF - 1);
        if (rstn && bus.o_tvalid && bus.o_tready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL byte_unexpected: got %h with nothing expected at %0t",
                         {bus.o_tlast, bus.o_tdata}, $time);
            end else begin
                check("byte", 32'({bus.o_tlast, bus.o_tdata}), 32'(exp_q.pop_front()));
            end
        end
        if (rstn && o_flush) begin
            n_chk++;
            if (flush_exp == 0) begin
                n_fail++;
                $display("FAIL flush_unexpected: got o_flush=1 expected 0 at %0t", $time);
            end else begin
                flush_exp--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   seen;
        logic ok;

        in_idle();
        bus.o_tready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_i_tready",   32'(bus.i_tready), 32'd0);
        check("rst_o_tvalid",   32'(bus.o_tvalid), 32'd0);
        check("rst_o_tdata",    32'(bus.o_tdata),  32'd0);
        check("rst_o_tlast",    32'(bus.o_tlast),  32'd0);
        check("rst_o_flush",    32'(o_flush),      32'd0);
        check("rst_fifo_level", 32'(fifo_level),   32'd0);
        check("rst_state",      32'(dbg_state),    32'(ST_IDLE));
        rstn = 1'b1;
        @(negedge clk);
        check("i_tready_after_release", 32'(bus.i_tready), 32'd1);

        // Full-keep beat: latency and consecutive bytes
        bus.o_tready = 1'b1;
        push_beat(32'h44332211, 4'b1111, 1'b1);
        in_idle();
        check("lat_edge1_valid", 32'(bus.o_tvalid), 32'd0);
        check("lat_edge1_level", 32'(fifo_level),   32'd1);
        @(negedge clk);
        check("lat_edge2_valid", 32'(bus.o_tvalid), 32'd0);
        @(negedge clk);
        check("lat_edge3_valid", 32'(bus.o_tvalid), 32'd1);
        check("lat_first_byte",  32'(bus.o_tdata),  32'h11);
        check("lat_level_after_load", 32'(fifo_level), 32'd0);
        count_burst(4, cyc, ok);
        check("full_burst_done",   32'(ok),  32'd1);
        check("full_burst_cycles", 32'(cyc), 32'd4);
        drain("drain_full");

        // Partial keep
        push_beat(32'hAABBCCDD, 4'b0111, 1'b1);
        in_idle();
        drain("drain_keep0111");

        // Non-contiguous keep
        push_beat(32'h11223344, 4'b1010, 1'b1);
        in_idle();
        drain("drain_keep1010");

        // Back-pressure: 4 beats buffered + 1 in the serializer
        bus.o_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push_beat(32'h03020100 + 32'(k) * 32'h04040404, 4'b1111, 1'b1 && (k == 4));
        end
        in_idle();
        check("bp_i_tready", 32'(bus.i_tready), 32'd0);
        check("bp_level",    32'(fifo_level),   32'd4);
        check("bp_valid",    32'(bus.o_tvalid), 32'd1);
        check("bp_hold_data", 32'(bus.o_tdata), 32'h00);
        repeat (3) @(negedge clk);
        check("bp_level_hold",    32'(fifo_level),   32'd4);
        check("bp_i_tready_hold", 32'(bus.i_tready), 32'd0);
        bus.o_tready = 1'b1;
        count_burst(20, cyc, ok);
        check("bp_burst_done",   32'(ok),  32'd1);
        check("bp_burst_cycles", 32'(cyc), 32'd20);
        drain("drain_backpressure");

        // Data beat followed by null end-of-transfer beat
        push_beat(32'h00000021, 4'b1111, 1'b0);
        push_beat(32'h00000000, 4'b0000, 1'b1);
        in_idle();
        count_burst(4, cyc, ok);
        check("null_burst_done", 32'(ok), 32'd1);
        @(negedge clk);
        check("flush_pulse",  32'(o_flush), 32'(FLUSH_ON));
        @(negedge clk);
        check("flush_single", 32'(o_flush), 32'd0);
        drain("drain_null");

        // Reset mid-packet after two bytes
        push_beat(32'h44332211, 4'b1111, 1'b1);
        in_idle();
        count_burst(2, cyc, ok);
        check("mid_burst_done", 32'(ok), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_o_tvalid", 32'(bus.o_tvalid), 32'd0);
        check("mid_rst_o_tdata",  32'(bus.o_tdata),  32'd0);
        check("mid_rst_o_tlast",  32'(bus.o_tlast),  32'd0);
        check("mid_rst_o_flush",  32'(o_flush),      32'd0);
        check("mid_rst_level",    32'(fifo_level),   32'd0);
        check("mid_rst_i_tready", 32'(bus.i_tready), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.o_tvalid) seen++;
        end
        check("no_residual_bytes", 32'(seen), 32'd0);

        // Recovery after reset
        push_beat(32'hDEADBEEF, 4'b1111, 1'b1);
        in_idle();
        drain("drain_recovery");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("flush_all_seen",   32'(flush_exp),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_tx_downsizer.md
AXIS_TX_DOWNSIZER -- requirements
Module: axis_tx_downsizer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning number of 32-bit beats buffered; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  single clock for all logic.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 i_tready  output  1  upstream beat accept (AXI-stream slave).
REQ-005 i_tvalid  input  1  upstream beat valid.
REQ-006 i_tdata  input  32  beat data; byte 0 = bits 7:0.
REQ-007 i_tkeep  input  4  byte enables; bit n qualifies byte n.
REQ-008 i_tlast  input  1  last beat of packet.
REQ-009 o_tready  input  1  downstream byte accept (USB FIFO side).
REQ-010 o_tvalid  output  1  output byte valid.
REQ-011 o_tdata  output  8  output byte.
REQ-012 o_tlast  output  1  marks the last byte of a packet.
REQ-013 o_flush  output  1  one-cycle "send immediate" pulse (see Configuration).
REQ-014 fifo_level  output  5  number of beats currently held in the FIFO.

Function
REQ-015 A beat transfers on an i_tvalid&i_tready edge; i_tready = FIFO not full.
REQ-016 A byte transfers on an o_tvalid&o_tready edge; o_tvalid/o_tdata/o_tlast stay stable until that edge.
REQ-017 Serializer states: IDLE (no word loaded), SHIFT (emitting bytes), FLUSH (REQ-024 only); the state returns to IDLE only when the FIFO is empty.
REQ-018 IDLE->SHIFT when the FIFO is non-empty; on the load, the word pops, keep is latched, and the first set keep byte is presented.
REQ-019 Bytes are emitted in ascending byte index, skipping bytes whose keep bit is 0; non-contiguous keep is legal.
REQ-020 o_tlast = 1 only on the highest set keep byte of a beat whose tlast = 1.
REQ-021 On the handshake of a word's final byte, the next FIFO word loads in the same edge; a full-keep stream sustains 1 byte/clk with no bubble.
REQ-022 Latency: with the FIFO empty and the serializer in IDLE, o_tvalid rises 2 clocks after the accepting input edge.
REQ-023 Null beat (keep = 0000) is popped and produces no byte; if its tlast = 0 it is simply discarded.
REQ-024 Null beat with tlast = 1 (upstream emits this as its end-of-transfer beat): the serializer enters FLUSH, which is handled per Configuration.
REQ-025 A FIFO push and pop in the same cycle leave fifo_level unchanged; when full, no push occurs and i_tready = 0.

Reset
REQ-026 While rstn = 0: FIFO empty, fifo_level = 0, state IDLE, o_tvalid = 0, o_tdata = 0, o_tlast = 0, o_flush = 0, i_tready = 0.
REQ-027 Reset mid-packet discards all buffered and partially emitted data; no byte is emitted after reset release until a new beat is accepted.
REQ-028 i_tready rises on the first clock after rstn deasserts.

Configuration
REQ-029 Macro AXIS_TX_FLUSH_EN: when defined, FLUSH waits until the last prior byte has handshaken, then pulses o_flush for exactly 1 clock, then moves to SHIFT/IDLE.
REQ-030 Without AXIS_TX_FLUSH_EN: o_flush is tied 0, FLUSH is not implemented, and a null-last beat is discarded like REQ-023.

Structure
REQ-031 The shared package holds the serializer state typedef, the FIFO_DEPTH default, and the byte-width/keep-width constants.
REQ-032 The FIFO is the sub-module axis_word_fifo (37-bit entries: data, keep, last; sync, fall-through not required).

Verification
REQ-033 Beat 0x44332211, keep 1111, last 1, o_tready = 1 -> bytes 11,22,33,44 on consecutive clocks, o_tlast only on 44, first byte 2 clocks after accept.
REQ-034 Beat 0xAABBCCDD, keep 0111, last 1 -> DD,CC,BB; o_tlast on BB; AA never emitted.
REQ-035 5 back-to-back full beats, o_tready = 0 -> i_tready drops after 4 beats in FIFO + 1 beat in serializer, fifo_level = 4; release -> 20 bytes, no gaps, order preserved.
REQ-036 Beat 0x00000021 keep 1111 last 0, then null keep 0000 last 1 -> 4 bytes with no o_tlast; with AXIS_TX_FLUSH_EN, o_flush pulses 1 clock after byte 4's handshake; without it, o_flush stays 0.
REQ-037 rstn pulsed low after 2 of 4 bytes emitted -> all outputs zero, fifo_level = 0, no residual bytes after release.
REQ-038 Keep 1010 on 0x11223344 -> bytes 33 then 11.
